// File: rtl/mor1kx_multiport_dpram_sclk.sv
// Single-clock RAM with one byte-masked write port and NUM_RD_PORTS registered read ports.
// Define MOR1KX_DPRAM_HWCLEAR_EN to build in the zero-fill sweep that runs after every reset.
module mor1kx_multiport_dpram_sclk #(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_RD_PORTS  = 2,
    parameter int unsigned ENABLE_BYPASS = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   raddr,
    input  logic [NUM_RD_PORTS-1:0]              re,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic                                 we,
    input  logic [DATA_WIDTH/8-1:0]              wbe,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   dout,
    output logic                                 busy
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    clr_we;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    wr_en;

    logic [ADDR_WIDTH-1:0]   rd_addr [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]   rd_data [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] dout_q;

`ifdef MOR1KX_DPRAM_HWCLEAR_EN
    typedef enum logic {StClear, StReady} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (&cnt_q) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                end
                default: begin
                    state_q <= StClear;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_we   = rst_n & (state_q == StClear);
    assign clr_addr = cnt_q;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // External writes are locked out during reset and while the sweep owns the array.
    assign wr_en = we & ~busy & rst_n;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wbe[k]) begin
                    mem[waddr][8*k +: 8] <= din[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd_addr
        assign rd_addr[g] = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Merge the write bytes so a same-address read sees the word as it will be after this edge.
    always_comb begin
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_data[i] = mem[rd_addr[i]];
            if ((ENABLE_BYPASS != 0) && wr_en && (rd_addr[i] == waddr)) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (wbe[k]) begin
                        rd_data[i][8*k +: 8] = din[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (busy) begin
            dout_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (re[i]) begin
                    dout_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data[i];
                end
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_mor1kx_multiport_dpram_sclk.sv
// Directed bench: one instance with bypass enabled, one without, sharing all inputs.
module tb_mor1kx_multiport_dpram_sclk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  raddr;
    logic [1:0]  re;
    logic [3:0]  waddr;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] din;
    logic [63:0] dout_b;
    logic [63:0] dout_n;
    logic        busy_b;
    logic        busy_n;

    int n_checks = 0;
    int n_errors = 0;

    mor1kx_multiport_dpram_sclk #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .NUM_RD_PORTS (2),
        .ENABLE_BYPASS(1)
    ) dut_byp (
        .clk  (clk),
        .rst_n(rst_n),
        .raddr(raddr),
        .re   (re),
        .waddr(waddr),
        .we   (we),
        .wbe  (wbe),
        .din  (din),
        .dout (dout_b),
        .busy (busy_b)
    );

    mor1kx_multiport_dpram_sclk #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .NUM_RD_PORTS (2),
        .ENABLE_BYPASS(0)
    ) dut_nob (
        .clk  (clk),
        .rst_n(rst_n),
        .raddr(raddr),
        .re   (re),
        .waddr(waddr),
        .we   (we),
        .wbe  (wbe),
        .din  (din),
        .dout (dout_n),
        .busy (busy_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] en);
        raddr = {a1, a0};
        re    = en;
    endtask

    task automatic set_wr(input logic en, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        we    = en;
        waddr = a;
        din   = d;
        wbe   = be;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        set_rd(4'd0, 4'd0, 2'b00);
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        tick();
        check_eq("reset_dout0_byp", dout_b[31:0], 32'h0);
        check_eq("reset_dout1_byp", dout_b[63:32], 32'h0);
        check_eq("reset_dout0_nob", dout_n[31:0], 32'h0);

`ifdef MOR1KX_DPRAM_HWCLEAR_EN
        check_eq("reset_busy", {31'd0, busy_b}, 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (busy_b && n < 100) begin
            tick();
            n++;
        end
        check_eq("sweep_cycles", n, 16);
        check_eq("sweep_done_nob", {31'd0, busy_n}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            set_rd(4'(a), 4'(15 - a), 2'b11);
            tick();
            check_eq($sformatf("clear_p0_a%0d", a), dout_b[31:0], 32'h0);
            check_eq($sformatf("clear_p1_a%0d", 15 - a), dout_b[63:32], 32'h0);
        end
        set_rd(4'd0, 4'd0, 2'b00);
`else
        rst_n = 1'b1;
        tick();
        check_eq("busy_tied_low", {31'd0, busy_b}, 32'd0);
        set_wr(1'b1, 4'd4, 32'h0, 4'hF);
        tick();
`endif

        // Full-word write then read on two ports.
        set_wr(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(4'd3, 4'd4, 2'b11);
        tick();
        check_eq("wr_rd_p0", dout_b[31:0], 32'hDEADBEEF);
        check_eq("wr_rd_p1", dout_b[63:32], 32'h0);
        check_eq("wr_rd_p0_nob", dout_n[31:0], 32'hDEADBEEF);

        // Byte-masked read-during-write on both ports.
        set_rd(4'd0, 4'd0, 2'b00);
        set_wr(1'b1, 4'd5, 32'h11223344, 4'hF);
        tick();
        set_wr(1'b1, 4'd5, 32'hAABBCCDD, 4'h5);
        set_rd(4'd5, 4'd5, 2'b11);
        tick();
        check_eq("rdw_byp_p0", dout_b[31:0], 32'h11BB33DD);
        check_eq("rdw_byp_p1", dout_b[63:32], 32'h11BB33DD);
        check_eq("rdw_nob_p0", dout_n[31:0], 32'h11223344);
        check_eq("rdw_nob_p1", dout_n[63:32], 32'h11223344);
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        check_eq("after_rdw_byp", dout_b[31:0], 32'h11BB33DD);
        check_eq("after_rdw_nob", dout_n[63:32], 32'h11BB33DD);

        // Write with no byte enables changes nothing, bypassed or not.
        set_wr(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
        tick();
        check_eq("wbe0_byp", dout_b[31:0], 32'h11BB33DD);
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        check_eq("wbe0_mem", dout_n[63:32], 32'h11BB33DD);

        // Hold with re low while the word underneath is overwritten.
        set_rd(4'd3, 4'd5, 2'b01);
        tick();
        check_eq("hold_pre", dout_b[31:0], 32'hDEADBEEF);
        set_rd(4'd3, 4'd3, 2'b00);
        set_wr(1'b1, 4'd3, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("hold_c%0d", c), dout_b[31:0], 32'hDEADBEEF);
            check_eq($sformatf("hold_p1_c%0d", c), dout_b[63:32], 32'h11BB33DD);
        end
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(4'd3, 4'd3, 2'b01);
        tick();
        check_eq("hold_post", dout_b[31:0], 32'h0);

        set_wr(1'b1, 4'd2, 32'h12345678, 4'hF);
        set_rd(4'd0, 4'd0, 2'b00);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);

`ifdef MOR1KX_DPRAM_HWCLEAR_EN
        // Interrupt a sweep at counter 9, then watch the restarted sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) tick();
        check_eq("mid_sweep_busy", {31'd0, busy_b}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("mid_reset_dout", dout_b[31:0], 32'h0);
        rst_n = 1'b1;
        set_rd(4'd5, 4'd2, 2'b11);
        n = 0;
        while (busy_b && n < 100) begin
            set_wr(n == 12, 4'd2, 32'hFFFFFFFF, 4'hF);
            tick();
            n++;
            check_eq($sformatf("sweep_dout0_c%0d", n), dout_b[31:0], 32'h0);
            check_eq($sformatf("sweep_dout1_c%0d", n), dout_b[63:32], 32'h0);
        end
        check_eq("resweep_cycles", n, 16);
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        check_eq("resweep_a5", dout_b[31:0], 32'h0);
        check_eq("resweep_a2", dout_b[63:32], 32'h0);
`else
        // Reset clears outputs but leaves the array intact.
        set_rd(4'd5, 4'd2, 2'b11);
        tick();
        rst_n = 1'b0;
        set_rd(4'd0, 4'd0, 2'b00);
        tick();
        check_eq("rst_dout0", dout_b[31:0], 32'h0);
        check_eq("rst_dout1", dout_n[63:32], 32'h0);
        rst_n = 1'b1;
        set_rd(4'd5, 4'd2, 2'b11);
        tick();
        check_eq("rst_keep_a5", dout_b[31:0], 32'h11BB33DD);
        check_eq("rst_keep_a2", dout_n[63:32], 32'h12345678);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mor1kx_multiport_dpram_sclk.md
MOR1KX_MULTIPORT_DPRAM_SCLK -- requirements
Module: mor1kx_multiport_dpram_sclk

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, address width; depth is 2^ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; DATA_WIDTH SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, number of independent read ports, legal range 1..4.
REQ-004 The block SHALL have parameter ENABLE_BYPASS, default 1; a value of 1 enables write-to-read forwarding.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port raddr, input, NUM_RD_PORTS*ADDR_WIDTH bits: read addresses; port i uses slice i.
REQ-008 The block SHALL have port re, input, NUM_RD_PORTS bits: per-port read enables.
REQ-009 The block SHALL have port waddr, input, ADDR_WIDTH bits: write address.
REQ-010 The block SHALL have port we, input, 1 bit: write enable.
REQ-011 The block SHALL have port wbe, input, DATA_WIDTH/8 bits: byte write enables; bit k covers din[8k+7:8k].
REQ-012 The block SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL have port dout, output, NUM_RD_PORTS*DATA_WIDTH bits: read data; port i uses slice i.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the clear sweep owns the array.

Function
REQ-015 Write: when we=1 and busy=0 at a clock edge, each byte k with wbe[k]=1 SHALL be written to mem[waddr]; bytes with wbe[k]=0 SHALL remain unchanged.
REQ-016 Read: when re[i]=1 and busy=0 at a clock edge, dout slice i SHALL present mem[raddr slice i] after that edge, giving a latency of 1 cycle.
REQ-017 Hold: while re[i]=0, dout slice i SHALL hold its last value, including any bypassed bytes.
REQ-018 Read-during-write with ENABLE_BYPASS=1: when re[i], we and raddr_i==waddr are all true at one edge, dout slice i SHALL show din bytes where wbe=1 and old memory bytes elsewhere; the result equals the new contents.
REQ-019 Read-during-write with ENABLE_BYPASS=0: same-address read-during-write SHALL return the old contents of the word.
REQ-020 Each read port SHALL evaluate bypass independently; several ports reading waddr at once SHALL all receive the merged word.
REQ-021 A write with we=1 and wbe=0 SHALL change neither memory nor any bypass result.
REQ-022 While busy=1, the external we and re SHALL be ignored and dout SHALL hold 0.

Reset
REQ-023 When rst_n=0 at an edge, every dout slice SHALL become 0 and all bypass state SHALL clear.
REQ-024 Array contents SHALL NOT be altered by reset itself, except through the clear sweep described under Configuration.
REQ-025 The first edge with rst_n=1 SHALL accept normal read and write operations if busy=0.

Configuration
REQ-026 Macro MOR1KX_DPRAM_HWCLEAR_EN SHALL, when defined, compile in the hardware clear sequencer; its FSM states are CLEAR and READY.
REQ-027 With MOR1KX_DPRAM_HWCLEAR_EN defined, rst_n=0 SHALL force state CLEAR, set the sweep counter to 0 and set busy=1.
REQ-028 With MOR1KX_DPRAM_HWCLEAR_EN defined, in CLEAR each edge with rst_n=1 SHALL write all-zero to mem[counter] and increment the counter.
REQ-029 With MOR1KX_DPRAM_HWCLEAR_EN defined, the write to address 2^ADDR_WIDTH-1 SHALL move the FSM to READY with busy=0, so busy is high for exactly 2^ADDR_WIDTH cycles after rst_n deasserts.
REQ-030 With MOR1KX_DPRAM_HWCLEAR_EN defined, a reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-031 Without MOR1KX_DPRAM_HWCLEAR_EN, no sequencer SHALL exist, busy SHALL be tied 0 and array contents after power-up SHALL be undefined.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_RD_PORTS=2)
REQ-032 Scenario: macro defined, release rst_n, count cycles -> busy=1 for exactly 16 cycles, then a read of addresses 0..15 returns 0x00000000.
REQ-033 Scenario: write 0xDEADBEEF to addr 3 with wbe=0xF; next cycle read port0 addr 3 and port1 addr 4 -> dout0=0xDEADBEEF, dout1=0x00000000.
REQ-034 Scenario: addr 5 holds 0x11223344; same edge write din=0xAABBCCDD with wbe=0x5 to addr 5 and read addr 5 on both ports with bypass=1 -> both dout=0x11BB33DD; with bypass=0 -> both dout=0x11223344.
REQ-035 Scenario: read addr 3 (0xDEADBEEF), then hold re=0 for 3 cycles while writing 0x0 to addr 3 -> dout0 stays 0xDEADBEEF.
REQ-036 Scenario: assert rst_n=0 at sweep counter 9, then release -> busy is high for 16 more cycles and dout=0 throughout; a we pulse during the sweep leaves its target at 0.
